// File: rtl/uart_tx_fsm_if.sv
// ============================================================================
// Module   : uart_tx_fsm_if
// Brief    : Word handshake, CTS and serial-line bundle for uart_tx_fsm.
//            Inject_Err exists only when UART_TX_ERR_INJECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_Data_In;
  logic                 Tx_Valid;
  logic                 Tx_Ready;
  logic                 CTS;
  logic                 Tx_Out;
  logic                 Tx_Busy;
  logic                 Tx_Done;
`ifdef UART_TX_ERR_INJECT_EN
  logic [1:0]           Inject_Err;

  modport master (
    output Tx_Data_In, Tx_Valid, CTS, Inject_Err,
    input  Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );
  modport slave (
    input  Tx_Data_In, Tx_Valid, CTS, Inject_Err,
    output Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );
`else
  modport master (
    output Tx_Data_In, Tx_Valid, CTS,
    input  Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );
  modport slave (
    input  Tx_Data_In, Tx_Valid, CTS,
    output Tx_Ready, Tx_Out, Tx_Busy, Tx_Done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/uart_tx_fsm.sv
// ============================================================================
// Module   : uart_tx_fsm
// Brief    : One-bit-per-clock UART transmitter, MSB first, optional even
//            parity, CTS-gated frame starts, one-entry holding register.
//            Optional macro UART_TX_ERR_INJECT_EN adds parity/stop corruption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int PARITY_BIT = 1,
  parameter int IDLE_GAP   = 2
) (
  input  wire logic    Clk,
  input  wire logic    Rst,
  uart_tx_fsm_if.slave tx
);

  localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] c_stop_last = CNT_W'(STOP_BITS - 1);
  localparam logic [3:0]       c_gap_last  = 4'(IDLE_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_full;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nx;
  logic [3:0]           r_gcnt;
  logic [3:0]           w_gcnt_nx;
  logic                 r_tx;
  logic                 w_tx_nx;
  logic                 r_done;
  logic                 w_load;
  logic                 w_chg;
  logic                 w_err_par;
  logic                 w_err_stop;

`ifdef UART_TX_ERR_INJECT_EN
  logic [1:0]           r_inj;

  always_ff @(posedge Clk) begin
    if (Rst)
      r_inj <= 2'b00;
    else if (w_load)
      r_inj <= tx.Inject_Err;
  end

  assign w_err_par  = r_inj[0];
  assign w_err_stop = r_inj[1];
`else
  assign w_err_par  = 1'b0;
  assign w_err_stop = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full && tx.CTS) begin
          w_state_nx = S_START;
          w_load     = 1'b1;
        end
      end
      S_START:  w_state_nx = S_DATA;
      S_DATA: begin
        if (r_cnt == c_data_last)
          w_state_nx = (PARITY_BIT != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: w_state_nx = S_STOP;
      S_STOP: begin
        if (r_cnt == c_stop_last)
          w_state_nx = S_GAP;
      end
      S_GAP: begin
        if (r_gcnt == c_gap_last)
          w_state_nx = S_IDLE;
      end
      default:  w_state_nx = S_IDLE;
    endcase

    w_chg     = (w_state_nx != r_state);
    w_cnt_nx  = '0;
    w_gcnt_nx = 4'd0;
    if (!w_chg && (r_state == S_DATA || r_state == S_STOP))
      w_cnt_nx = r_cnt + CNT_W'(1);
    if (!w_chg && r_state == S_GAP)
      w_gcnt_nx = r_gcnt + 4'd1;

    // The line is registered, so it is driven from the state being entered.
    case (w_state_nx)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = r_shreg[DATA_BITS-1];
      S_PARITY: w_tx_nx = r_par ^ w_err_par;
      S_STOP:   w_tx_nx = !(w_err_stop && (w_cnt_nx == c_stop_last));
      default:  w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_full  <= 1'b0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
      r_gcnt  <= 4'd0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_gcnt  <= w_gcnt_nx;
      r_tx    <= w_tx_nx;
      r_done  <= (w_state_nx == S_GAP) && (r_state != S_GAP);
      if (w_load) begin
        r_shreg <= r_buf;
        r_par   <= ^r_buf;
        r_full  <= 1'b0;
      end else if (w_state_nx == S_DATA) begin
        r_shreg <= {r_shreg[DATA_BITS-2:0], 1'b0};
      end
      // Drain requires full and accept requires empty, so they never collide.
      if (tx.Tx_Valid && !r_full) begin
        r_buf  <= tx.Tx_Data_In;
        r_full <= 1'b1;
      end
    end
  end

  assign tx.Tx_Ready = !r_full;
  assign tx.Tx_Out   = r_tx;
  assign tx.Tx_Busy  = (r_state != S_IDLE);
  assign tx.Tx_Done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
// ============================================================================
// Module   : tb_uart_tx_fsm
// Brief    : Directed bench for uart_tx_fsm with a frame-position line model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fsm;

  localparam int DB    = 8;
  localparam int SB    = 2;
  localparam int PB    = 1;
  localparam int GAP   = 2;
  localparam int FRAME = 1 + DB + PB + SB;
  localparam int TOTAL = FRAME + GAP;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  uart_tx_fsm_if #(.DATA_BITS(DB)) bus ();

  uart_tx_fsm #(
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_BIT(PB),
    .IDLE_GAP  (GAP)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .tx (bus.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // Line image of one frame plus gap; index 0 is the start bit.
  function automatic logic [31:0] build_frame(input logic [DB-1:0] w, input logic [1:0] inj);
    logic [31:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1+i] = w[DB-1-i];
    if (PB != 0) f[1+DB] = (^w) ^ inj[0];
    if (inj[1]) f[FRAME-1] = 1'b0;
    return f;
  endfunction

  bit          m_full = 1'b0;
  logic [DB-1:0] m_word = '0;
  int          m_pos = -1;
  logic [31:0] m_frame = '1;

  always @(posedge Clk) begin
    bit         acc;
    logic [1:0] inj;
`ifdef UART_TX_ERR_INJECT_EN
    inj = bus.Inject_Err;
`else
    inj = 2'b00;
`endif
    if (Rst) begin
      m_full = 1'b0;
      m_pos  = -1;
    end else begin
      acc = bus.Tx_Valid && !m_full;
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == TOTAL) m_pos = -1;
      end else if (m_full && bus.CTS) begin
        m_frame = build_frame(m_word, inj);
        m_pos   = 0;
        m_full  = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_word = bus.Tx_Data_In;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("model_tx_out", bus.Tx_Out, (m_pos < 0) ? 1'b1 : m_frame[m_pos]);
      check("model_ready",  bus.Tx_Ready, !m_full);
      check("model_busy",   bus.Tx_Busy, m_pos >= 0);
      check("model_done",   bus.Tx_Done, m_pos == FRAME);
    end
  end

  initial begin
    int k;
    int m;
    logic [12:0] e_a5;
    bus.Tx_Data_In = '0;
    bus.Tx_Valid   = 1'b0;
    bus.CTS        = 1'b1;
`ifdef UART_TX_ERR_INJECT_EN
    bus.Inject_Err = 2'b00;
`endif
    repeat (3) @(negedge Clk);
    chk_en = 1'b1;
    check("rst_tx_out", bus.Tx_Out, 1'b1);
    check("rst_ready",  bus.Tx_Ready, 1'b1);
    check("rst_busy",   bus.Tx_Busy, 1'b0);
    check("rst_done",   bus.Tx_Done, 1'b0);
    Rst = 1'b0;
    @(negedge Clk);

    // Single word 0xA5: start, 10100101, parity 0, two stops, then mark.
    e_a5 = 13'b0101001010111;
    bus.Tx_Data_In = 8'hA5;
    bus.Tx_Valid   = 1'b1;
    k = cyc + 1;
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge Clk);
      check("a5_bit",  bus.Tx_Out, e_a5[13-i]);
      check("a5_done", bus.Tx_Done, i == 13);
    end
    repeat (4) @(negedge Clk);

    // Back-to-back 0x01 then 0xFF.
    bus.Tx_Data_In = 8'h01;
    bus.Tx_Valid   = 1'b1;
    k = cyc + 1;
    @(negedge Clk);
    bus.Tx_Data_In = 8'hFF;
    @(negedge Clk);
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    while (cyc < k + 26) begin
      if (cyc >= k + 2 && cyc <= k + 15) check("b2b_ready_low", bus.Tx_Ready, 1'b0);
      if (cyc == k + 15) check("b2b_mark_before", bus.Tx_Out, 1'b1);
      if (cyc == k + 16) begin
        check("b2b_second_start", bus.Tx_Out, 1'b0);
        check("b2b_ready_back",   bus.Tx_Ready, 1'b1);
      end
      if (cyc == k + 25) check("b2b_parity_ff", bus.Tx_Out, 1'b0);
      @(negedge Clk);
    end
    repeat (8) @(negedge Clk);

    // CTS hold with 0x3C, then release and drop mid-frame.
    bus.CTS        = 1'b0;
    bus.Tx_Data_In = 8'h3C;
    bus.Tx_Valid   = 1'b1;
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("cts_hold_tx",    bus.Tx_Out, 1'b1);
      check("cts_hold_ready", bus.Tx_Ready, 1'b0);
    end
    bus.CTS = 1'b1;
    m = cyc;
    @(negedge Clk);
    check("cts_start", bus.Tx_Out, 1'b0);
    repeat (3) @(negedge Clk);
    bus.CTS = 1'b0;
    while (cyc < m + 13) @(negedge Clk);
    check("cts_done_after_drop", bus.Tx_Done, 1'b1);
    repeat (4) @(negedge Clk);
    bus.CTS = 1'b1;

    // Reset during the 4th data bit with another word buffered.
    bus.Tx_Data_In = 8'hC3;
    bus.Tx_Valid   = 1'b1;
    k = cyc + 1;
    @(negedge Clk);
    bus.Tx_Data_In = 8'h5A;
    @(negedge Clk);
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    while (cyc < k + 5) @(negedge Clk);
    check("rstm_ready_full", bus.Tx_Ready, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    check("rstm_tx_out", bus.Tx_Out, 1'b1);
    check("rstm_busy",   bus.Tx_Busy, 1'b0);
    check("rstm_ready",  bus.Tx_Ready, 1'b1);
    Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("rstm_quiet", bus.Tx_Out, 1'b1);
    end

`ifdef UART_TX_ERR_INJECT_EN
    // 0x55 has even weight, so a correct parity bit would be 0.
    bus.Tx_Data_In = 8'h55;
    bus.Inject_Err = 2'b01;
    bus.Tx_Valid   = 1'b1;
    k = cyc + 1;
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    while (cyc < k + 10) @(negedge Clk);
    check("inj_parity", bus.Tx_Out, 1'b1);
    repeat (8) @(negedge Clk);
    bus.Inject_Err = 2'b10;
    bus.Tx_Valid   = 1'b1;
    k = cyc + 1;
    @(negedge Clk);
    bus.Tx_Valid = 1'b0;
    while (cyc < k + 11) @(negedge Clk);
    check("inj_first_stop", bus.Tx_Out, 1'b1);
    @(negedge Clk);
    check("inj_last_stop", bus.Tx_Out, 1'b0);
    repeat (6) @(negedge Clk);
    bus.Inject_Err = 2'b00;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
